// File: rtl/cal_cell.sv
// cal_cell: registered ALU slice, WIDTH bits wide.
// Each bit has a four-function logic unit and a full adder in a ripple chain.
// arit chooses which result is registered into out.
// c_out always carries the adder carry out of the MSB.
module cal_cell #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             arit,
  input  logic             c_in,
  input  logic [1:0]       s,
  output logic [WIDTH-1:0] out,
  output logic             c_out,
  output logic             out_valid
);

  // Logic function codes on s.
  localparam logic [1:0] FN_AND = 2'b00;
  localparam logic [1:0] FN_OR  = 2'b01;
  localparam logic [1:0] FN_XOR = 2'b10;
  localparam logic [1:0] FN_NOT = 2'b11;

  // Bitwise logic unit. Operand b is ignored for the NOT function.
  function automatic logic [WIDTH-1:0] logic_unit(
    input logic [WIDTH-1:0] la,
    input logic [WIDTH-1:0] lb,
    input logic [1:0]       ls
  );
    logic [WIDTH-1:0] r;
    case (ls)
      FN_AND:  r = la & lb;
      FN_OR:   r = la | lb;
      FN_XOR:  r = la ^ lb;
      FN_NOT:  r = ~la;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Unsigned ripple chain of WIDTH full adders.
  // Result is {carry out of the MSB, sum}; the sum wraps modulo 2^WIDTH.
  function automatic logic [WIDTH:0] ripple_add(
    input logic [WIDTH-1:0] ra,
    input logic [WIDTH-1:0] rb,
    input logic             rc
  );
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             p;
    carry = rc;
    for (int i = 0; i < WIDTH; i++) begin
      p      = ra[i] ^ rb[i];
      sum[i] = p ^ carry;
      carry  = (ra[i] & rb[i]) | (carry & p);
    end
    return {carry, sum};
  endfunction

  // ---- stage p0: combinational evaluation of the current inputs ----
  logic [WIDTH:0]   add_p0;
  logic [WIDTH-1:0] sum_p0;
  logic             carry_p0;
  logic [WIDTH-1:0] logic_p0;
  logic [WIDTH-1:0] out_next_p0;

  // Adder and logic unit both evaluate every cycle; arit selects the one registered.
  // Selecting with a mux (instead of gating s) keeps an unused s from affecting out.
  always_comb begin
    add_p0      = ripple_add(a, b, c_in);
    sum_p0      = add_p0[WIDTH-1:0];
    carry_p0    = add_p0[WIDTH];
    logic_p0    = logic_unit(a, b, s);
    out_next_p0 = arit ? sum_p0 : logic_p0;
  end

  // ---- stage p1: output registers ----
  logic [WIDTH-1:0] out_p1;
  logic             c_out_p1;
  logic             vld_p1;

  // Capture a result on every accepted input; hold data otherwise, valid is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_p1   <= '0;
      c_out_p1 <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        out_p1   <= out_next_p0;
        c_out_p1 <= carry_p0;
      end
    end
  end

  assign out       = out_p1;
  assign c_out     = c_out_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_cal_cell.sv
// Testbench for cal_cell: three instances (WIDTH 1, 4, 8) on one clock and reset.
module tb_cal_cell;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // WIDTH=1 instance
  logic       v1, ar1, ci1;
  logic [0:0] a1, b1;
  logic [1:0] s1;
  logic [0:0] o1;
  logic       co1, ov1;

  // WIDTH=4 instance
  logic       v4, ar4, ci4;
  logic [3:0] a4, b4;
  logic [1:0] s4;
  logic [3:0] o4;
  logic       co4, ov4;

  // WIDTH=8 instance
  logic       v8, ar8, ci8;
  logic [7:0] a8, b8;
  logic [1:0] s8;
  logic [7:0] o8;
  logic       co8, ov8;

  cal_cell #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .arit(ar1),
    .c_in(ci1), .s(s1), .out(o1), .c_out(co1), .out_valid(ov1)
  );

  cal_cell #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4), .arit(ar4),
    .c_in(ci4), .s(s4), .out(o4), .c_out(co4), .out_valid(ov4)
  );

  cal_cell #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .arit(ar8),
    .c_in(ci8), .s(s8), .out(o8), .c_out(co8), .out_valid(ov8)
  );

  // Reference model: plain integer arithmetic for width w. Returns {carry, result}.
  function automatic logic [32:0] ref_cell(input int w, input logic [31:0] ra,
                                           input logic [31:0] rb, input logic rarit,
                                           input logic rc, input logic [1:0] rs);
    longint unsigned m, tot, res;
    m   = (64'd1 << w) - 1;
    tot = (ra & m) + (rb & m) + rc;
    if (rarit) res = tot & m;
    else begin
      case (rs)
        2'd0:    res = ra & rb & m;
        2'd1:    res = (ra | rb) & m;
        2'd2:    res = (ra ^ rb) & m;
        default: res = (~ra) & m;
      endcase
    end
    return {((tot >> w) & 1) != 0, res[31:0]};
  endfunction

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    v1 = 0; v4 = 0; v8 = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    v1 = 1; a1 = 1; b1 = 1; ar1 = 1; ci1 = 1; s1 = 0;
    v4 = 1; a4 = 4'hF; b4 = 4'hF; ar4 = 1; ci4 = 1; s4 = 0;
    v8 = 1; a8 = 8'hFF; b8 = 8'hFF; ar8 = 1; ci8 = 1; s8 = 0;
    tick();
    tick();
    tests++;
    if ({o1, co1, ov1} !== 3'b000) begin
      fails++; $display("FAIL reset_w1: out,c_out,valid=%b required 000", {o1, co1, ov1});
    end
    tests++;
    if ({o4, co4, ov4} !== 6'b0) begin
      fails++; $display("FAIL reset_w4: out=%h c_out=%b valid=%b required 0 0 0", o4, co4, ov4);
    end
    tests++;
    if ({o8, co8, ov8} !== 10'b0) begin
      fails++; $display("FAIL reset_w8: out=%h c_out=%b valid=%b required 0 0 0", o8, co8, ov8);
    end
    idle_all();
    rst_n = 1;
    tick();
  endtask

  // Full (a,b,c_in) sweep of the single-bit adder against the truth table.
  task automatic test_add_w1();
    logic [1:0] tbl [8];
    tbl = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
    for (int i = 0; i < 8; i++) begin
      v1 = 1; ar1 = 1; s1 = 2'b00;
      a1 = 1'((i >> 2) & 1); b1 = 1'((i >> 1) & 1); ci1 = 1'(i & 1);
      tick();
      tests++;
      if ({o1, co1, ov1} !== {tbl[i], 1'b1}) begin
        fails++;
        $display("FAIL add_w1[%0d]: out,c_out,valid=%b required %b", i, {o1, co1, ov1}, {tbl[i], 1'b1});
      end
    end
    v1 = 0;
  endtask

  task automatic test_logic_w1();
    logic exp [4];
    exp = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      v1 = 1; ar1 = 0; a1 = 1; b1 = 0; ci1 = 0; s1 = 2'(i);
      tick();
      tests++;
      if ({o1, co1, ov1} !== {exp[i], 1'b0, 1'b1}) begin
        fails++;
        $display("FAIL logic_w1[s=%0d]: out,c_out,valid=%b required %b", i, {o1, co1, ov1}, {exp[i], 2'b01});
      end
    end
    v1 = 1; ar1 = 0; a1 = 1; b1 = 1; ci1 = 1; s1 = 2'b01;
    tick();
    tests++;
    if ({o1, co1} !== 2'b11) begin
      fails++; $display("FAIL logic_carry_w1: out,c_out=%b required 11", {o1, co1});
    end
    v1 = 0;
  endtask

  task automatic test_overflow_w4();
    v4 = 1; ar4 = 1; a4 = 4'hF; b4 = 4'h1; ci4 = 0; s4 = 2'b10;
    tick();
    tests++;
    if ({o4, co4, ov4} !== {4'h0, 1'b1, 1'b1}) begin
      fails++; $display("FAIL overflow_w4: out=%h c_out=%b valid=%b required 0 1 1", o4, co4, ov4);
    end
    // Idle with different operand values: outputs must hold, valid must drop.
    v4 = 0; a4 = 4'h3; b4 = 4'h4; ar4 = 0; ci4 = 1;
    tick();
    tests++;
    if ({o4, co4, ov4} !== {4'h0, 1'b1, 1'b0}) begin
      fails++; $display("FAIL hold_w4: out=%h c_out=%b valid=%b required 0 1 0", o4, co4, ov4);
    end
  endtask

  task automatic test_back_to_back_w4();
    logic [3:0] exp [4];
    exp = '{4'h8, 4'hE, 4'h6, 4'h5};
    for (int i = 0; i < 4; i++) begin
      v4 = 1; ar4 = 0; a4 = 4'hA; b4 = 4'hC; ci4 = 0; s4 = 2'(i);
      tick();
      tests++;
      // A+C = 0x16, so the carry is 1 regardless of the logic function.
      if ({o4, co4, ov4} !== {exp[i], 1'b1, 1'b1}) begin
        fails++;
        $display("FAIL b2b_w4[s=%0d]: out=%h c_out=%b valid=%b required %h 1 1", i, o4, co4, ov4, exp[i]);
      end
    end
    v4 = 0;
  endtask

  task automatic test_reset_mid();
    v4 = 1; ar4 = 1; a4 = 4'h7; b4 = 4'h9; ci4 = 1; s4 = 0;
    tick();
    rst_n = 0;
    a4 = 4'h5; b4 = 4'h5;
    tick();
    tests++;
    if ({o4, co4, ov4} !== 6'b0) begin
      fails++; $display("FAIL reset_mid_w4: out=%h c_out=%b valid=%b required 0 0 0", o4, co4, ov4);
    end
    rst_n = 1;
    a4 = 4'h9; b4 = 4'h8; ci4 = 0;
    tick();
    tests++;
    if ({o4, co4, ov4} !== {4'h1, 1'b1, 1'b1}) begin
      fails++; $display("FAIL resume_w4: out=%h c_out=%b valid=%b required 1 1 1", o4, co4, ov4);
    end
    v4 = 0;
    tick();
  endtask

  // Random traffic on the 4- and 8-bit cells; the model keeps its own held state.
  task automatic test_random();
    logic [32:0] r4, r8;
    logic [3:0]  m_o4;
    logic [7:0]  m_o8;
    logic        m_c4, m_c8, m_v4, m_v8;
    rst_n = 0; idle_all();
    tick();
    rst_n = 1;
    m_o4 = 0; m_c4 = 0; m_o8 = 0; m_c8 = 0;
    for (int n = 0; n < 200; n++) begin
      v4 = ($urandom_range(0, 3) != 0); a4 = 4'($urandom); b4 = 4'($urandom);
      ar4 = 1'($urandom); ci4 = 1'($urandom); s4 = 2'($urandom);
      v8 = ($urandom_range(0, 3) != 0); a8 = 8'($urandom); b8 = 8'($urandom);
      ar8 = 1'($urandom); ci8 = 1'($urandom); s8 = 2'($urandom);
      r4 = ref_cell(4, 32'(a4), 32'(b4), ar4, ci4, s4);
      r8 = ref_cell(8, 32'(a8), 32'(b8), ar8, ci8, s8);
      if (v4) begin m_o4 = r4[3:0]; m_c4 = r4[32]; end
      if (v8) begin m_o8 = r8[7:0]; m_c8 = r8[32]; end
      m_v4 = v4; m_v8 = v8;
      tick();
      tests++;
      if ({o4, co4, ov4} !== {m_o4, m_c4, m_v4}) begin
        fails++;
        $display("FAIL rand_w4[%0d]: out=%h c_out=%b valid=%b required %h %b %b", n, o4, co4, ov4, m_o4, m_c4, m_v4);
      end
      tests++;
      if ({o8, co8, ov8} !== {m_o8, m_c8, m_v8}) begin
        fails++;
        $display("FAIL rand_w8[%0d]: out=%h c_out=%b valid=%b required %h %b %b", n, o8, co8, ov8, m_o8, m_c8, m_v8);
      end
    end
    idle_all();
  endtask

  initial begin
    rst_n = 0;
    idle_all();
    a1 = 0; b1 = 0; ar1 = 0; ci1 = 0; s1 = 0;
    a4 = 0; b4 = 0; ar4 = 0; ci4 = 0; s4 = 0;
    a8 = 0; b8 = 0; ar8 = 0; ci8 = 0; s8 = 0;
    #2;
    test_reset();
    test_add_w1();
    test_logic_w1();
    test_overflow_w4();
    test_back_to_back_w4();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
